// File: rtl/ball_motion_updater.sv
`default_nettype none
// ============================================================================
//  Module      : ball_motion_updater
//  Description : Owns one ball's position and speed. Once per frame it applies
//                wall-collision results, cue strikes, friction and position
//                integration with table-edge clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_updater #(
    parameter int RADIUS       = 16,
    parameter int TABLE_WIDTH  = 800,
    parameter int TABLE_HEIGHT = 600,
    parameter int INIT_X       = 200,
    parameter int INIT_Y       = 300,
    parameter int MAX_SPEED    = 31,
    parameter int FRIC_PERIOD  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [1:0]         collision,
    input  logic signed [10:0] new_xspeed,
    input  logic signed [10:0] new_yspeed,
    input  logic               cue_hit,
    input  logic signed [10:0] cue_xspeed,
    input  logic signed [10:0] cue_yspeed,
    output logic signed [10:0] x,
    output logic signed [10:0] y,
    output logic signed [10:0] xspeed,
    output logic signed [10:0] yspeed,
    output logic               moving,
    output logic               update_done,
    output logic               overrun
);

    localparam int CNT_W = (FRIC_PERIOD > 1) ? $clog2(FRIC_PERIOD) : 1;

    localparam logic signed [11:0] X_MIN   = 12'(RADIUS);
    localparam logic signed [11:0] X_MAX   = 12'(TABLE_WIDTH - RADIUS);
    localparam logic signed [11:0] Y_MIN   = 12'(RADIUS);
    localparam logic signed [11:0] Y_MAX   = 12'(TABLE_HEIGHT - RADIUS);
    localparam logic signed [10:0] SPD_MAX = 11'(MAX_SPEED);
    localparam logic signed [10:0] SPD_MIN = -11'(MAX_SPEED);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(FRIC_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        COLL = 3'd1,
        FRIC = 3'd2,
        MOVE = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic signed [10:0] x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic signed [10:0] xspd_q, xspd_d;
    logic signed [10:0] yspd_q, yspd_d;
    logic [1:0]         coll_q, coll_d;
    logic signed [10:0] nxs_q, nxs_d;
    logic signed [10:0] nys_q, nys_d;
    logic [CNT_W-1:0]   fric_cnt_q, fric_cnt_d;
    logic               update_done_q, update_done_d;
    logic               overrun_q, overrun_d;

    logic               cue_accept;
    logic signed [10:0] fric_xs;
    logic signed [10:0] fric_ys;
    logic signed [11:0] x_sum;
    logic signed [11:0] y_sum;

    function automatic logic signed [10:0] sat_speed(input logic signed [10:0] v);
        if (v > SPD_MAX)
            return SPD_MAX;
        else if (v < SPD_MIN)
            return SPD_MIN;
        else
            return v;
    endfunction

    function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
        if (v > 11'sd0)
            return v - 11'sd1;
        else if (v < 11'sd0)
            return v + 11'sd1;
        else
            return v;
    endfunction

    function automatic logic signed [10:0] clamp_pos(input logic signed [11:0] v,
                                                     input logic signed [11:0] lo,
                                                     input logic signed [11:0] hi);
        logic signed [11:0] r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return r[10:0];
    endfunction

    assign moving     = (xspd_q != 11'sd0) || (yspd_q != 11'sd0);
    assign cue_accept = (state_q == IDLE) && cue_hit && !moving;

    // Sign-extend to 12 bits so an edge overshoot is seen before clamping.
    assign x_sum = {x_q[10], x_q} + {xspd_q[10], xspd_q};
    assign y_sum = {y_q[10], y_q} + {yspd_q[10], yspd_q};

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        xspd_d        = xspd_q;
        yspd_d        = yspd_q;
        coll_d        = coll_q;
        nxs_d         = nxs_q;
        nys_d         = nys_q;
        fric_cnt_d    = fric_cnt_q;
        update_done_d = 1'b0;
        overrun_d     = overrun_q | (frame_tick && (state_q != IDLE));
        fric_xs       = xspd_q;
        fric_ys       = yspd_q;

        case (state_q)
            IDLE: begin
                if (cue_accept) begin
                    xspd_d     = sat_speed(cue_xspeed);
                    yspd_d     = sat_speed(cue_yspeed);
                    fric_cnt_d = '0;
                end
                if (frame_tick) begin
                    // Checker data predates a simultaneous strike, so discard it.
                    coll_d  = cue_accept ? 2'b00 : collision;
                    nxs_d   = new_xspeed;
                    nys_d   = new_yspeed;
                    state_d = COLL;
                end
            end
            COLL: begin
                if (coll_q[1])
                    xspd_d = nxs_q;
                if (coll_q[0])
                    yspd_d = nys_q;
                state_d = FRIC;
            end
            FRIC: begin
                if (moving) begin
                    if (fric_cnt_q == CNT_TOP) begin
                        fric_cnt_d = '0;
                        fric_xs    = toward_zero(xspd_q);
                        fric_ys    = toward_zero(yspd_q);
                    end else begin
                        fric_cnt_d = fric_cnt_q + CNT_W'(1);
                    end
                end
                xspd_d  = sat_speed(fric_xs);
                yspd_d  = sat_speed(fric_ys);
                state_d = MOVE;
            end
            MOVE: begin
                x_d           = clamp_pos(x_sum, X_MIN, X_MAX);
                y_d           = clamp_pos(y_sum, Y_MIN, Y_MAX);
                update_done_d = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= 11'(INIT_X);
            y_q           <= 11'(INIT_Y);
            xspd_q        <= '0;
            yspd_q        <= '0;
            coll_q        <= 2'b00;
            nxs_q         <= '0;
            nys_q         <= '0;
            fric_cnt_q    <= '0;
            update_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            xspd_q        <= xspd_d;
            yspd_q        <= yspd_d;
            coll_q        <= coll_d;
            nxs_q         <= nxs_d;
            nys_q         <= nys_d;
            fric_cnt_q    <= fric_cnt_d;
            update_done_q <= update_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign xspeed      = xspd_q;
    assign yspeed      = yspd_q;
    assign update_done = update_done_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire
